mmio_uart: RTL and testbench



---
 rtl/mmio_uart_pkg.sv | 41 ++++
 rtl/mmio_uart_rx_core.sv | 95 +++++++++
 rtl/mmio_uart.sv | 158 +++++++++++++++
 tb/tb_mmio_uart.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mmio_uart_pkg.sv
// Shared types and bit positions for the memory-mapped 8N1 UART.
package mmio_uart_pkg;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} UARTTxState_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} UARTRxState_t;

  // controlWord fields (core -> UART)
  localparam int unsigned UART_TX_TOGGLE_BIT     = 8;
  localparam int unsigned UART_RX_ACK_BIT        = 9;

  // statusWord fields (UART -> core)
  localparam int unsigned UART_RX_TOGGLE_BIT     = 8;
  localparam int unsigned UART_TX_ACK_BIT        = 9;
  localparam int unsigned UART_BUSY_BIT          = 10;
  localparam int unsigned UART_RX_PENDING_BIT    = 11;
  localparam int unsigned UART_FRAMING_ERROR_BIT = 12;
  localparam int unsigned UART_OVERRUN_BIT       = 13;

  // Assemble the status word; unused upper bits read as zero.
  function automatic logic [31:0] packStatus(
    input logic [7:0] rxData,
    input logic       rxToggle,
    input logic       txAckToggle,
    input logic       txBusy,
    input logic       rxPending,
    input logic       framingError,
    input logic       overrun
  );
    logic [31:0] word;
    word = '0;
    word[7:0]                    = rxData;
    word[UART_RX_TOGGLE_BIT]     = rxToggle;
    word[UART_TX_ACK_BIT]        = txAckToggle;
    word[UART_BUSY_BIT]          = txBusy;
    word[UART_RX_PENDING_BIT]    = rxPending;
    word[UART_FRAMING_ERROR_BIT] = framingError;
    word[UART_OVERRUN_BIT]       = overrun;
    return word;
  endfunction

endpackage

// File: rtl/mmio_uart_rx_core.sv
// Receive half of the UART: pin synchroniser, 8N1 framing FSM and shift register.
// Emits single-cycle byteValid / framingError pulses at mid-stop-bit.
module mmio_uart_rx_core
  import mmio_uart_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_BIT = 434
)
(
  input  logic       clock,
  input  logic       reset,
  input  logic       rxPin,
  output logic       byteValid,
  output logic [7:0] byteData,
  output logic       framingError
);

  localparam int unsigned     CNT_W     = $clog2(CLOCKS_PER_BIT);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLOCKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLOCKS_PER_BIT / 2 - 1);

  logic             rxSync1, rxSync2;
  UARTRxState_t     state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic [2:0]       bitIdx, bitIdxNext;
  logic [7:0]       shift, shiftNext;

  assign byteData = shift;

  // Two-flop synchroniser, idles high like the line.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rxSync1 <= 1'b1;
      rxSync2 <= 1'b1;
    end else begin
      rxSync1 <= rxPin;
      rxSync2 <= rxSync1;
    end
  end

  // RX FSM state, bit timer, bit index and shift register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= RX_IDLE;
      cnt    <= '0;
      bitIdx <= '0;
      shift  <= '0;
    end else begin
      state  <= stateNext;
      cnt    <= cntNext;
      bitIdx <= bitIdxNext;
      shift  <= shiftNext;
    end
  end

  // Next-state: half-bit to confirm start, then sample each bit at its centre.
  always_comb begin
    stateNext    = state;
    cntNext      = cnt + 1'b1;
    bitIdxNext   = bitIdx;
    shiftNext    = shift;
    byteValid    = 1'b0;
    framingError = 1'b0;
    case (state)
      RX_IDLE: begin
        cntNext = '0;
        if (!rxSync2) stateNext = RX_START;
      end
      RX_START: begin
        if (cnt == HALF_LAST) begin
          cntNext    = '0;
          bitIdxNext = '0;
          stateNext  = rxSync2 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt == FULL_LAST) begin
          cntNext    = '0;
          shiftNext  = {rxSync2, shift[7:1]};
          bitIdxNext = bitIdx + 1'b1;
          if (bitIdx == 3'd7) stateNext = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt == FULL_LAST) begin
          cntNext   = '0;
          stateNext = RX_IDLE;
          if (rxSync2) byteValid    = 1'b1;
          else         framingError = 1'b1;
        end
      end
      default: stateNext = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/mmio_uart.sv
// 8N1 UART on the core's MMIO words. All handshakes are toggle based because
// MMIO writes carry no strobe.
module mmio_uart
  import mmio_uart_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_BIT = 434
)
(
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] controlWord,
  output logic [31:0] statusWord,
  input  logic        uartRx,
  output logic        uartTx
);

  localparam int unsigned     CNT_W    = $clog2(CLOCKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLOCKS_PER_BIT - 1);

  UARTTxState_t     txState, txStateNext;
  logic [CNT_W-1:0] txCnt, txCntNext;
  logic [2:0]       txBit, txBitNext;
  logic [7:0]       txShift, txShiftNext;
  logic             txAck, txAckNext;
  logic             txBusy, txBusyNext;
  logic             txPinNext, txAccept, txSendReq, txBitEnd;

  logic       rxByteValid, rxFrameErr;
  logic [7:0] rxByte;
  logic [7:0] rxData;
  logic       rxToggle, rxPending, rxAckPrev, rxAckChange;
  logic       framingError, overrun;
  logic       unusedCtrl;

  assign unusedCtrl = ^controlWord[31:10];

  assign txSendReq   = controlWord[UART_TX_TOGGLE_BIT] != txAck;
  assign txBitEnd    = txCnt == BIT_LAST;
  assign rxPending   = rxToggle ^ controlWord[UART_RX_ACK_BIT];
  assign rxAckChange = controlWord[UART_RX_ACK_BIT] != rxAckPrev;

  // TX FSM registers; the pin is registered from the next state so it is glitch free.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      txState <= TX_IDLE;
      txCnt   <= '0;
      txBit   <= '0;
      txShift <= '0;
      txAck   <= 1'b0;
      txBusy  <= 1'b0;
      uartTx  <= 1'b1;
    end else begin
      txState <= txStateNext;
      txCnt   <= txCntNext;
      txBit   <= txBitNext;
      txShift <= txShiftNext;
      txAck   <= txAckNext;
      txBusy  <= txBusyNext;
      uartTx  <= txPinNext;
    end
  end

  // TX next-state. A pending toggle is also accepted on the last stop-bit cycle
  // so chained frames leave no idle gap on the line.
  always_comb begin
    txStateNext = txState;
    txCntNext   = txCnt;
    txBitNext   = txBit;
    txShiftNext = txShift;
    txAckNext   = txAck;
    txBusyNext  = txBusy;
    txAccept    = 1'b0;
    txPinNext   = 1'b1;
    case (txState)
      TX_IDLE: txAccept = txSendReq;
      TX_START: begin
        txCntNext = txCnt + 1'b1;
        if (txBitEnd) begin
          txCntNext   = '0;
          txStateNext = TX_DATA;
        end
      end
      TX_DATA: begin
        txCntNext = txCnt + 1'b1;
        if (txBitEnd) begin
          txCntNext = '0;
          if (txBit == 3'd7) begin
            txStateNext = TX_STOP;
          end else begin
            txBitNext   = txBit + 1'b1;
            txShiftNext = {1'b0, txShift[7:1]};
          end
        end
      end
      TX_STOP: begin
        txCntNext = txCnt + 1'b1;
        if (txBitEnd) begin
          txCntNext   = '0;
          txBusyNext  = 1'b0;
          txStateNext = TX_IDLE;
          txAccept    = txSendReq;
        end
      end
      default: txStateNext = TX_IDLE;
    endcase
    if (txAccept) begin
      txStateNext = TX_START;
      txShiftNext = controlWord[7:0];
      txAckNext   = controlWord[UART_TX_TOGGLE_BIT];
      txBusyNext  = 1'b1;
      txCntNext   = '0;
      txBitNext   = '0;
    end
    case (txStateNext)
      TX_START: txPinNext = 1'b0;
      TX_DATA:  txPinNext = txShiftNext[0];
      default:  txPinNext = 1'b1;
    endcase
  end

  mmio_uart_rx_core #(
    .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
  ) rxCore (
    .clock       (clock),
    .reset       (reset),
    .rxPin       (uartRx),
    .byteValid   (rxByteValid),
    .byteData    (rxByte),
    .framingError(rxFrameErr)
  );

  // RX delivery and error flags; a new error in the same cycle as an ack wins.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rxData       <= '0;
      rxToggle     <= 1'b0;
      rxAckPrev    <= 1'b0;
      framingError <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      rxAckPrev <= controlWord[UART_RX_ACK_BIT];
      if (rxByteValid) begin
        rxData   <= rxByte;
        rxToggle <= ~rxToggle;
      end
      if (rxByteValid && rxPending) overrun <= 1'b1;
      else if (rxAckChange)         overrun <= 1'b0;
      if (rxFrameErr)       framingError <= 1'b1;
      else if (rxAckChange) framingError <= 1'b0;
    end
  end

  // Status word assembly.
  always_comb begin
    statusWord = packStatus(rxData, rxToggle, txAck, txBusy, rxPending, framingError, overrun);
  end

endmodule

// File: tb/tb_mmio_uart.sv
// Directed + randomized bench for mmio_uart with a frame-level reference model.
module tb_mmio_uart;

  localparam int unsigned CPB = 4;

  logic        clock;
  logic        reset;
  logic [31:0] controlWord;
  logic [31:0] statusWord;
  logic        uartRx;
  logic        uartTx;

  mmio_uart #(.CLOCKS_PER_BIT(CPB)) dut (
    .clock      (clock),
    .reset      (reset),
    .controlWord(controlWord),
    .statusWord (statusWord),
    .uartRx     (uartRx),
    .uartTx     (uartTx)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int passCount = 0;
  int checkCount = 0;

  // software-side control fields
  logic [7:0] ctlData;
  logic       ctlSend, ctlAck;

  // reference model of the visible peripheral state
  logic [7:0] mRxData;
  logic       mRxTog, mTxAck, mBusy, mFerr, mOvr;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive();
    logic [31:0] r;
    r = $urandom;
    controlWord = {r[31:10], ctlAck, ctlSend, ctlData};
  endtask

  function automatic logic [31:0] expStatus();
    logic [31:0] w;
    w = '0;
    w[7:0] = mRxData;
    w[8]   = mRxTog;
    w[9]   = mTxAck;
    w[10]  = mBusy;
    w[11]  = mRxTog ^ ctlAck;
    w[12]  = mFerr;
    w[13]  = mOvr;
    return w;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic modelRx(input logic [7:0] d, input logic stopBit);
    if (stopBit) begin
      if (mRxTog ^ ctlAck) mOvr = 1'b1;
      mRxData = d;
      mRxTog  = ~mRxTog;
    end else begin
      mFerr = 1'b1;
    end
  endtask

  task automatic ackFlip();
    ctlAck = ~ctlAck;
    drive();
    tick();
    mFerr = 1'b0;
    mOvr  = 1'b0;
    check("ackStatus", statusWord, expStatus());
  endtask

  // Called right after the edge that starts the frame; checks all 40 cycles.
  // Optionally queues the next byte part-way through the frame.
  task automatic txFrame(input logic [7:0] d, input bit chain, input logic [7:0] nd);
    logic [9:0] f;
    f = {1'b1, d, 1'b0};
    for (int k = 0; k < 10 * CPB; k++) begin
      check("txPin", {31'b0, uartTx}, {31'b0, f[k / CPB]});
      check("txStatus", statusWord, expStatus());
      if (chain && k == 10) begin
        ctlData = nd;
        ctlSend = ~ctlSend;
        drive();
      end
      tick();
    end
  endtask

  task automatic rxFrame(input logic [7:0] d, input logic stopBit);
    logic [9:0] f;
    f = {stopBit, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      uartRx = f[b];
      repeat (CPB) tick();
    end
    uartRx = 1'b1;
    repeat (6) tick();
    modelRx(d, stopBit);
    check("rxStatus", statusWord, expStatus());
  endtask

  initial begin
    logic [7:0] d, nd;
    logic       sb;

    reset = 1'b1;
    controlWord = '0;
    uartRx = 1'b1;
    ctlData = '0; ctlSend = 1'b0; ctlAck = 1'b0;
    mRxData = '0; mRxTog = 1'b0; mTxAck = 1'b0; mBusy = 1'b0; mFerr = 1'b0; mOvr = 1'b0;
    repeat (3) tick();
    check("resetStatus", statusWord, 32'h0);
    check("resetTx", {31'b0, uartTx}, 32'h1);
    reset = 1'b0;
    tick();
    check("idleStatus", statusWord, 32'h0);
    check("idleTx", {31'b0, uartTx}, 32'h1);

    // single frame 0x55 (controlWord low bits 0x155)
    ctlData = 8'h55; ctlSend = 1'b1; drive();
    tick();
    mTxAck = 1'b1; mBusy = 1'b1;
    txFrame(8'h55, 1'b0, 8'h00);
    mBusy = 1'b0;
    check("txDoneStatus", statusWord, expStatus());
    check("txDonePin", {31'b0, uartTx}, 32'h1);
    repeat (3) tick();

    // chained frames: random, then 0x0A queued mid-frame, then random chain
    d = 8'($urandom);
    ctlData = d; ctlSend = ~ctlSend; drive();
    tick();
    mTxAck = ctlSend; mBusy = 1'b1;
    nd = 8'h0A;
    for (int i = 0; i < 5; i++) begin
      txFrame(d, i < 4, nd);
      if (i < 4) begin
        mTxAck = ctlSend;
        d = nd;
        nd = 8'($urandom);
      end
    end
    mBusy = 1'b0;
    check("chainDoneStatus", statusWord, expStatus());
    check("chainDonePin", {31'b0, uartTx}, 32'h1);

    // RX directed
    rxFrame(8'hC3, 1'b1);
    ackFlip();
    rxFrame(8'h11, 1'b1);
    rxFrame(8'h22, 1'b1);
    ackFlip();
    rxFrame(8'h5A, 1'b0);
    uartRx = 1'b0; tick(); uartRx = 1'b1;
    repeat (8) tick();
    check("glitchStatus", statusWord, expStatus());
    ackFlip();
    rxFrame(8'h96, 1'b1);

    // RX randomized
    for (int i = 0; i < 10; i++) begin
      d  = 8'($urandom);
      sb = ($urandom_range(0, 3) != 0);
      rxFrame(d, sb);
      if ($urandom_range(0, 1) == 1) ackFlip();
    end

    // reset mid-frame
    if (ctlAck) ackFlip();
    ctlData = 8'($urandom); ctlSend = ~ctlSend; drive();
    tick();
    check("preResetTx", {31'b0, uartTx}, 32'h0);
    repeat (9) tick();
    reset = 1'b1;
    #1;
    check("midResetTx", {31'b0, uartTx}, 32'h1);
    check("midResetStatus", statusWord, 32'h0);
    controlWord = '0;
    ctlData = '0; ctlSend = 1'b0; ctlAck = 1'b0;
    mRxData = '0; mRxTog = 1'b0; mTxAck = 1'b0; mBusy = 1'b0; mFerr = 1'b0; mOvr = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    for (int k = 0; k < 10 * CPB + 4; k++) begin
      tick();
      check("postResetTx", {31'b0, uartTx}, 32'h1);
      check("postResetStatus", statusWord, expStatus());
    end

    // recovery frame after reset
    d = 8'($urandom);
    ctlData = d; ctlSend = 1'b1; drive();
    tick();
    mTxAck = 1'b1; mBusy = 1'b1;
    txFrame(d, 1'b0, 8'h00);
    mBusy = 1'b0;
    check("recoverStatus", statusWord, expStatus());

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
